// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle controller.
// Holds FSM state codes, ALUOp/ALUSrcB codes, opcode/funct constants
// and the instruction-class codes produced by mc_decode.
package mc_pkg;

  // FSM states; codes 5-7 are unused and recover to FETCH
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Instruction classes resolved by the decoder
  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_ORI = 3'd1,
    CL_LW  = 3'd2,
    CL_SW  = 3'd3,
    CL_BEQ = 3'd4
  } iclass_e;

  // ALU opcodes (110/111 are never produced)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_SEXT = 2'd1;
  localparam logic [1:0] SRCB_ZEXT = 2'd2;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  // Memory-access classes go through the MEM state
  function automatic logic is_mem(input logic [2:0] cls);
    return (cls == CL_LW) || (cls == CL_SW);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational IR decode into legality, class,
// ALU opcode and B-operand select.
// Optional feature: MC_CTRL_BEQ_EN makes beq a legal instruction.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] ir,
  output logic        legal,
  output logic [2:0]  cls,
  output logic [2:0]  aluop,
  output logic [1:0]  alusrcb
);

  logic [5:0] opc;
  logic [5:0] fn;
  logic       unused_ir_bits;

  assign opc = ir[31:26];
  assign fn  = ir[5:0];
  // register/immediate fields matter only to the datapath
  assign unused_ir_bits = ^ir[25:6];

  // opcode/funct lookup; anything not matched stays illegal
  always_comb begin
    legal   = 1'b0;
    cls     = CL_R;
    aluop   = ALU_ADD;
    alusrcb = SRCB_RT;
    case (opc)
      OP_RTYPE: begin
        cls   = CL_R;
        legal = 1'b1;
        case (fn)
          FN_ADDU: aluop = ALU_ADD;
          FN_SUBU: aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SRL:  aluop = ALU_SRL;
          FN_SRA:  aluop = ALU_SRA;
          default: legal = 1'b0;
        endcase
      end
      OP_ORI: begin
        legal   = 1'b1;
        cls     = CL_ORI;
        aluop   = ALU_OR;
        alusrcb = SRCB_ZEXT;
      end
      OP_LW: begin
        legal   = 1'b1;
        cls     = CL_LW;
        alusrcb = SRCB_SEXT;
      end
      OP_SW: begin
        legal   = 1'b1;
        cls     = CL_SW;
        alusrcb = SRCB_SEXT;
      end
`ifdef MC_CTRL_BEQ_EN
      OP_BEQ: begin
        legal = 1'b1;
        cls   = CL_BEQ;
        aluop = ALU_SUB;
      end
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB controller.
// Holds the state register, the instruction register and the output
// decode; instruction decoding lives in mc_decode.
// Optional feature: define MC_CTRL_BEQ_EN to support beq (PCSrc is
// otherwise tied low and beq decodes as illegal).
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [2:0]  ALUOp,
  output logic [1:0]  ALUSrcB,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        Illegal,
  output logic [2:0]  State
);

  state_e      state_q, state_d;
  logic [31:0] ir_q;

  logic        dec_legal;
  logic [2:0]  dec_cls;
  logic [2:0]  dec_aluop;
  logic [1:0]  dec_srcb;

`ifndef MC_CTRL_BEQ_EN
  // Zero only steers beq
  logic unused_zero;
  assign unused_zero = Zero;
`endif

  mc_decode u_dec (
    .ir      (ir_q),
    .legal   (dec_legal),
    .cls     (dec_cls),
    .aluop   (dec_aluop),
    .alusrcb (dec_srcb)
  );

  // state register; reset returns to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // IR captures the fetched word only while IRWrite is high
  always_ff @(posedge clk) begin
    if (reset)        ir_q <= '0;
    else if (IRWrite) ir_q <= Instr;
  end

  // next-state and output decode; reset overrides everything to 0
  always_comb begin
    state_d  = ST_FETCH;
    ALUOp    = ALU_ADD;
    ALUSrcB  = SRCB_RT;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    Illegal  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          Illegal = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        ALUOp   = dec_aluop;
        ALUSrcB = dec_srcb;
        if (is_mem(dec_cls))     state_d = ST_MEM;
        else if (dec_cls == CL_BEQ) begin
`ifdef MC_CTRL_BEQ_EN
          PCSrc   = 1'b1;
          PCWrite = Zero;
`endif
          state_d = ST_FETCH;
        end
        else                     state_d = ST_WB;
      end
      ST_MEM: begin
        // strobe held until the memory acknowledges
        if (dec_cls == CL_LW) MemRead  = 1'b1;
        else                  MemWrite = 1'b1;
        if (MemReady) state_d = (dec_cls == CL_LW) ? ST_WB : ST_FETCH;
        else          state_d = ST_MEM;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        RegDst   = (dec_cls == CL_R);
        MemtoReg = (dec_cls == CL_LW);
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (reset) begin
      state_d  = ST_FETCH;
      ALUOp    = ALU_ADD;
      ALUSrcB  = SRCB_RT;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      Illegal  = 1'b0;
    end
  end

  // debug state, forced to 0 during reset
  assign State = reset ? 3'd0 : state_q;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-002 SHALL have ports, in order: clk in 1 (clock); reset in 1 (sync reset); Instr in 32 (fetched word, valid in FETCH); Zero in 1 (datapath equality flag, valid in EXEC); MemReady in 1 (data-memory done).
REQ-003 SHALL have output ports: ALUOp out 3 (ALU opcode); ALUSrcB out 2 (0 = rt reg, 1 = sign-ext imm, 2 = zero-ext imm); IRWrite out 1; PCWrite out 1; PCSrc out 1 (0 = PC+4, 1 = branch target); MemRead out 1; MemWrite out 1; RegWrite out 1; RegDst out 1 (0 = rt, 1 = rd); MemtoReg out 1; Illegal out 1 (one-cycle pulse); State out 3 (debug).

Function
REQ-004 ALUOp encoding SHALL be 000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra. Codes 110 and 111 SHALL never be driven.
REQ-005 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 SHALL return to FETCH on the next edge.
REQ-006 FETCH: IRWrite=1, PCWrite=1, PCSrc=0. Instr SHALL be latched into an internal IR at the clock edge. Next state is DECODE.
REQ-007 DECODE: all enables 0. If the IR holds a legal instruction, next state is EXEC. Otherwise Illegal=1 for this cycle and next state is FETCH.
REQ-008 Legal R-type (opcode 000000) by funct: addu 100001→000, subu 100011→001, and 100100→010, or 100101→011, srl 000010→100, sra 000011→101. Any other funct is illegal.
REQ-009 Legal I-type: ori 001101 (ALUOp 011, ALUSrcB 2); lw 100011 and sw 101011 (ALUOp 000, ALUSrcB 1).
REQ-010 EXEC: ALUOp and ALUSrcB SHALL be driven from the IR. Next state: R-type/ori → WB; lw/sw → MEM.
REQ-011 MEM: lw drives MemRead=1 and sw drives MemWrite=1. The strobe SHALL be held every cycle until MemReady=1. On the cycle MemReady=1, lw → WB and sw → FETCH. A MemReady high in any other state SHALL be ignored.
REQ-012 WB: RegWrite=1 for exactly one cycle. RegDst=1 for R-type, 0 for ori/lw. MemtoReg=1 only for lw. Next state is FETCH.
REQ-013 Outside EXEC, ALUOp SHALL be 000 and ALUSrcB 0. Outside the listed cases, every enable SHALL be 0.
REQ-014 Latency with zero memory wait: R-type/ori 4 cycles, sw 4 cycles, lw 5 cycles. Each MemReady-low cycle SHALL add 1 cycle.
REQ-015 In WB and MEM, no two of RegWrite, MemWrite and IRWrite SHALL be high in the same cycle.

Reset
REQ-016 While reset=1 at a clock edge, the next state SHALL be FETCH and the IR SHALL be cleared to 0.
REQ-017 While reset=1, every output SHALL be forced to 0 (State=0) in that cycle, overriding the state decode.
REQ-018 Reset asserted during MEM or WB SHALL abandon the instruction. No RegWrite, MemRead or MemWrite SHALL follow until a new fetch.

Configuration
REQ-019 Macro MC_CTRL_BEQ_EN SHALL gate beq support.
REQ-020 With the macro defined, beq (000100) is legal. EXEC drives ALUOp=001, ALUSrcB=0, PCSrc=1 and PCWrite=Zero (combinational on Zero), then returns to FETCH (3-cycle latency).
REQ-021 Without the macro, opcode 000100 SHALL be illegal per REQ-007, and PCSrc SHALL be tied to 0.

Structure
REQ-022 Package mc_pkg SHALL hold the state encodings, the ALUOp codes, the ALUSrcB codes and the opcode/funct constants.
REQ-023 Sub-module mc_decode SHALL be purely combinational: IR → {legal, class, ALUOp, ALUSrcB}. mc_ctrl SHALL hold only the state register, the IR and the output decode.

Verification
REQ-024 Reset, then Instr=0x00221821 (addu $3,$1,$2) → State 0,1,2,4,0. In EXEC: ALUOp=000, ALUSrcB=0. In WB: RegWrite=1, RegDst=1, MemtoReg=0.
REQ-025 Instr=0x8C220004 (lw) with MemReady low for 2 cycles → MemRead held for 3 cycles. WB has MemtoReg=1, RegDst=0. Total 7 cycles.
REQ-026 Instr=0x00011043 (sra) → EXEC ALUOp=101. Instr=0x34220FFF (ori) → EXEC ALUOp=011, ALUSrcB=2.
REQ-027 Instr=0xFC000000 → Illegal=1 in DECODE only, back to FETCH, no RegWrite or MemWrite.
REQ-028 sw with reset asserted during MEM → MemWrite=0 in the reset cycle. State=0 next, and no WB follows.
REQ-029 With MC_CTRL_BEQ_EN: beq with Zero=1 → PCWrite=1 and PCSrc=1 in EXEC. With Zero=0 → PCWrite=0. Without the macro, the same word gives Illegal=1.
